muldiv_unit: RTL
================

# muldiv_unit

Iterative 32-bit multiply/divide unit for the EX stage of the pipelined MIPS datapath. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the HI/LO architectural registers. Its `result` output drives the second data input of the EX-stage 32-bit result mux, which selects between the ALU result and HI/LO for MFHI/MFLO. The hazard unit uses `busy` to stall the pipeline while an operation is in flight.

## Interface
- None: no parameters. The datapath width is fixed at 32 bits.

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; accepted only when `busy`=0 and `flush`=0
- `op`  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are accepted but have no effect and produce no `done`
- `rs_val`  in  32  multiplicand or dividend; source for MTHI/MTLO
- `rt_val`  in  32  multiplier or divisor
- `flush`  in  1  abort the operation in flight
- `hilo_sel`  in  1  read select: 0 selects LO, 1 selects HI
- `busy`  out  1  high while the state is RUN or FINISH
- `done`  out  1  one-cycle pulse after HI/LO are written
- `result`  out  32  combinational: `hilo_sel` ? HI : LO

## Operation
- FSM states are IDLE, RUN and FINISH.
- IDLE, start accepted with a mul/div op:
  - latch the operand magnitudes and sign flags;
  - clear the 6-bit iteration counter;
  - go to RUN.
- Operands are latched at accept. Later changes on `rs_val`/`rt_val` have no effect.
- RUN:
  - one iteration per cycle, 32 iterations;
  - go to FINISH when the counter reaches 31.
- Multiply datapath: shift-add on unsigned magnitudes into a 64-bit accumulator.
- Divide datapath: restoring division on magnitudes, with a 32-bit remainder and 32-bit quotient.
- FINISH: sign fix-up, write HI/LO, set `done`, go to IDLE.
- Product sign rules:
  - MULT: 64-bit two's-complement product, HI = [63:32], LO = [31:0];
  - MULTU: unsigned product.
- Quotient sign rules:
  - DIV quotient truncates toward zero; LO = quotient, HI = remainder;
  - remainder sign follows the dividend.
- Divide by zero (signed or unsigned): HI = `rs_val` as latched, LO = 32'hFFFF_FFFF.
- Signed overflow, 32'h8000_0000 / -1: LO = 32'h8000_0000, HI = 0.
- MTHI/MTLO complete in a single cycle:
  - HI or LO is written at the accepting edge;
  - the state stays IDLE;
  - `done` pulses in the next cycle.
- `start` while `busy`=1 is ignored; no queuing.
- `flush`=1 in RUN or FINISH:
  - go to IDLE at the next edge;
  - HI/LO unchanged, no `done`.
- `flush` and `start` in the same IDLE cycle: `flush` wins and the start is dropped.
- Reset (async, any state):
  - state IDLE;
  - HI = LO = 0;
  - `busy` = 0, `done` = 0, counter = 0;
  - an operation in flight is discarded.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high at its ending edge.
- Mul/div:
  - `busy`=1 in cycles 1–33 (RUN in 1–32, FINISH in 33);
  - HI/LO are written at the end of cycle 33;
  - `done`=1 and `busy`=0 in cycle 34, and `result` shows the new value in that cycle;
  - a new `start` can be accepted in cycle 34.
- MTHI/MTLO: `busy` never rises; `done`=1 in cycle 1; the new value is visible on `result` in cycle 1.
- `result` is purely combinational from HI/LO and `hilo_sel`, with no added latency.
- `done` is registered and lasts exactly one cycle.

## Test plan
- MULT with rs = 32'hFFFF_FFFF, rt = 2 → HI = FFFF_FFFF, LO = FFFF_FFFE, `done` in cycle 34. MULTU with the same operands → HI = 1, LO = FFFF_FFFE.
- DIV −7 / 2 → LO = FFFF_FFFD, HI = FFFF_FFFF. DIVU 100 / 7 → LO = 14, HI = 2.
- DIV 123 / 0 → HI = 123, LO = FFFF_FFFF. DIV 8000_0000 / FFFF_FFFF → LO = 8000_0000, HI = 0.
- `start` pulsed in cycle 5 of a running MULT → ignored; exactly one `done`. Assert `flush` in cycle 10 of a DIV → IDLE, no `done`, HI/LO retain their prior values.
- MTHI 0xDEAD_BEEF, then MTLO 0x1234_5678 → `result` = DEADBEEF with `hilo_sel`=1 and 12345678 with `hilo_sel`=0. Assert `rst_n` low mid-MULT → `busy`, `done`, HI and LO all 0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit owning the HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU in 32 iterations (shift-add / restoring
// division on magnitudes, sign fix-up at the end) and MTHI/MTLO in one cycle.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request, accepted when idle and not flushed
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   rs_val    multiplicand / dividend / MTHI-MTLO source
//   rt_val    multiplier / divisor
//   flush     abort the operation in flight
//   hilo_sel  read select, 1 = HI, 0 = LO
//   busy      high while RUN or FINISH
//   done      one-cycle pulse after HI/LO are written
//   result    combinational HI or LO
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO complete here
// RUN    | one shift-add or restoring-divide iteration per cycle
// FINISH | sign fix-up, HI/LO write, done
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        hilo_sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q;
    logic [31:0] mag_b_q;
    logic [31:0] rs_q;
    logic [31:0] hi_q, lo_q;
    logic [5:0]  cnt_q;
    logic        neg_a_q, neg_b_q, signed_q, div_q, done_q;

    logic        accept, is_muldiv, is_mt, sgn_op, neg_a, neg_b;
    logic [31:0] mag_a, mag_b;

    assign accept    = (state_q == S_IDLE) && start && !flush;
    assign is_muldiv = ~op[2];
    assign is_mt     = op[2] & ~op[1];
    assign sgn_op    = ~op[0];
    assign neg_a     = sgn_op & rs_val[31];
    assign neg_b     = sgn_op & rt_val[31];
    assign mag_a     = neg_a ? (~rs_val + 32'd1) : rs_val;
    assign mag_b     = neg_b ? (~rt_val + 32'd1) : rt_val;

    // Multiply: acc = {partial product, remaining multiplier bits}
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient}
    // When the trial value is >= divisor the true difference fits in 32 bits,
    // so the low-word subtraction is exact.
    logic [32:0] div_try;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    assign div_try  = {acc_q[63:32], acc_q[31]};
    assign div_ge   = div_try >= {1'b0, mag_b_q};
    assign div_rem  = div_ge ? (div_try[31:0] - mag_b_q) : div_try[31:0];
    assign div_next = {div_rem, acc_q[30:0], div_ge};

    // Sign fix-up; 8000_0000 / -1 falls out naturally as LO = 8000_0000, HI = 0
    logic        neg_res;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign neg_res  = signed_q & (neg_a_q ^ neg_b_q);
    assign prod_fix = neg_res ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix  = neg_res ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix  = (signed_q & neg_a_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && is_muldiv) state_d = S_RUN;
            S_RUN:    if (flush) state_d = S_IDLE;
                      else if (cnt_q == 6'd31) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mag_b_q  <= '0;
            rs_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            signed_q <= 1'b0;
            div_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && is_muldiv) begin
                        acc_q    <= {32'd0, mag_a};
                        mag_b_q  <= mag_b;
                        rs_q     <= rs_val;
                        neg_a_q  <= neg_a;
                        neg_b_q  <= neg_b;
                        signed_q <= sgn_op;
                        div_q    <= op[1];
                        cnt_q    <= '0;
                    end else if (accept && is_mt) begin
                        if (op[0]) lo_q <= rs_val;
                        else       hi_q <= rs_val;
                        done_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        acc_q <= div_q ? div_next : mul_next;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_FINISH: begin
                    if (!flush) begin
                        if (!div_q) begin
                            hi_q <= prod_fix[63:32];
                            lo_q <= prod_fix[31:0];
                        end else if (mag_b_q == 32'd0) begin
                            hi_q <= rs_q;
                            lo_q <= 32'hFFFF_FFFF;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = hilo_sel ? hi_q : lo_q;

endmodule
